glitch_cmd_processor: RTL
=========================

# glitch_cmd_processor

Parametrised host-command decoder for the glitcher. It sits between the UART receiver and transmitter, parses the host byte protocol and drives `NUM_CH` independent glitch channels, each with its own duration and offset. It also supports the target reset pulse and a length-prefixed passthrough pipe to the target UART. Over the single-channel processor it adds:
- atomic parameter commits
- per-channel arming
- parameter readback
- inter-byte timeout recovery
- error and overflow reporting

## Interface
Parameters:
- `NUM_CH`, 2: glitch channels, 1..8.
- `PARAM_BYTES`, 4: bytes per duration/offset; `PW = 8*PARAM_BYTES`.
- `FIFO_DEPTH`, 16: tx FIFO entries, power of 2, ≥2.
- `RESET_CYCLES`, 1: `target_reset` pulse width, ≥1.
- `TIMEOUT_CYCLES`, 1200000: inter-byte timeout; 0 disables.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; asynchronous, active-low.
- `rx_data`  in  8  byte from UART receiver.
- `rx_valid`  in  1  one-cycle strobe qualifying `rx_data`.
- `tx_release`  in  1  gates FIFO drain.
- `tx_ready`  in  1  UART transmitter accepts byte.
- `tx_data`  out  8  FIFO head.
- `tx_valid`  out  1  `!fifo_empty & tx_release`.
- `target_reset`  out  1  target reset pulse.
- `duration`  out  NUM_CH*PW  per-channel duration; channel c at `[c*PW +: PW]`.
- `offset`  out  NUM_CH*PW  per-channel offset, same packing.
- `start_offset_counter`  out  NUM_CH  per-channel one-cycle start pulse.
- `armed`  out  NUM_CH  armed-channel mask.
- `cmd_error`  out  1  one-cycle pulse on protocol error.
- `fifo_overflow`  out  1  sticky; set when a byte is dropped.

## Operation
- Reset: all outputs 0, `duration`/`offset` 0, FIFO empty, state IDLE.
- Opcodes, one byte in IDLE:
  - 0x00 PASS `len` + `len` data bytes.
  - 0x01 RESET.
  - 0x02 SET_DUR `ch` + `PARAM_BYTES` bytes, LSB first.
  - 0x03 SET_OFF `ch` + bytes, LSB first.
  - 0x04 ARM `mask`.
  - 0x05 READBACK `ch`.
- States:
  - IDLE
  - PASS_LEN
  - PIPE
  - SEL_CH
  - LOAD
  - ARM_MASK
  - RB_SEL
  - READBACK
- Unknown opcode: byte dropped, `cmd_error` pulse, stay IDLE.
- PASS:
  - On the `len` byte, `start_offset_counter <= armed`, then `armed` clears.
  - `len`=0 returns to IDLE; otherwise the next `len` bytes are pushed to the FIFO, then IDLE.
- RESET: `target_reset` high for `RESET_CYCLES` cycles. A repeat RESET while active restarts the count.
- SET_DUR/SET_OFF:
  - Bytes shift into a `PW`-bit shadow register.
  - On the last byte the shadow commits to the selected channel in one cycle, so outputs never show partial values.
  - `ch ≥ NUM_CH`: bytes are still consumed, the commit is suppressed, and `cmd_error` pulses on the last byte.
- ARM: `armed <= mask[NUM_CH-1:0]`. Set bits ≥ `NUM_CH` → `cmd_error`, legal bits still applied.
- READBACK:
  - Pushes `PARAM_BYTES` duration bytes, then `PARAM_BYTES` offset bytes, LSB first, one per cycle, then IDLE.
  - Invalid `ch` → `cmd_error`, nothing pushed.
  - `rx_valid` during READBACK: byte dropped, `cmd_error` pulses.
- Timeout: in any state except IDLE/READBACK, a counter runs and clears on each `rx_valid`. Reaching `TIMEOUT_CYCLES` → IDLE, shadow discarded, `cmd_error` pulse.
- FIFO:
  - First-word fall-through; pop on `tx_valid & tx_ready`.
  - A push while full is dropped and sets `fifo_overflow`, unless a pop occurs in the same cycle.
  - `fifo_overflow` is cleared only by `rst` or a RESET command.

## Timing
- All outputs are registered. The effect of the byte at cycle N is visible at N+1:
  - commit
  - `target_reset` rise
  - `start_offset_counter` pulse
  - `armed` update
  - FIFO push
- `tx_valid` rises the cycle after the first push (if `tx_release` is high).
- READBACK: the first push is at N+1 after the `ch` byte, the last at N+2·`PARAM_BYTES`, and IDLE at the following cycle.
- ARM on `len` cycle: `start_offset_counter` uses the pre-update mask.
- `rst` asserted mid-command aborts immediately. The shadow is not committed and the FIFO is emptied.

## Structure
- Package `glitch_cmd_pkg` holds:
  - opcode constants `OP_PASS..OP_READBACK`
  - state enum `cmd_state_t`
- Sub-module `byte_fifo` (params `DEPTH`): `clk`, `rst`, `wen`, `din`, `ren`, `dout`, `empty`, `full`. The core FSM, counters and register bank stay in `glitch_cmd_processor`.

## Test plan
- NUM_CH=2: `02 01 78 56 34 12` → `duration[63:32]`=0x12345678 at one cycle, `duration[31:0]` unchanged. Mid-sequence probe shows the old value.
- `04 03`, `00 02 AA BB` → `start_offset_counter`=2'b11 for one cycle after `02`, then `armed`=0. `tx_data` sequence AA, BB with `tx_ready` held high.
- `05 00` after loading dur0=0x11223344, off0=0xA0B0C0D0 → FIFO outputs 44 33 22 11 D0 C0 B0 A0.
- `02 07 ...` (4 bytes) → no register change, `cmd_error` pulse on last byte. `09` → `cmd_error`, state IDLE.
- TIMEOUT_CYCLES=100: `03 00 55` then silence → IDLE at the 100th idle cycle, `cmd_error`. Following `01` → `target_reset` pulse of `RESET_CYCLES`.
- FIFO_DEPTH=4, `tx_release`=0: `00 06` + 6 bytes → first 4 stored, `fifo_overflow`=1. Then `01` clears it, and `tx_release`=1 drains 4 bytes.

Source files
------------

// File: rtl/glitch_cmd_pkg.sv
// glitch_cmd_pkg: host opcodes and command FSM state encoding
package glitch_cmd_pkg;
  localparam logic [7:0] OP_PASS     = 8'h00;
  localparam logic [7:0] OP_RESET    = 8'h01;
  localparam logic [7:0] OP_SET_DUR  = 8'h02;
  localparam logic [7:0] OP_SET_OFF  = 8'h03;
  localparam logic [7:0] OP_ARM      = 8'h04;
  localparam logic [7:0] OP_READBACK = 8'h05;
  typedef enum logic [2:0] {IDLE, PASS_LEN, PIPE, SEL_CH, LOAD, ARM_MASK, RB_SEL, READBACK} cmd_state_t;
endpackage

// File: rtl/glitch_cmd_processor_byte_fifo.sv
// byte_fifo: first-word fall-through byte FIFO; a push into a full FIFO survives only alongside a pop
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wen,
  input  logic [7:0] din,
  input  logic       ren,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic do_w, do_r;
  assign empty = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout = mem_q[rp_q[AW-1:0]];
  // pointer advance; the extra MSB distinguishes full from empty
  always_comb begin
    do_r = ren & !empty;
    do_w = wen & (!full | do_r);
    wp_d = wp_q + {{AW{1'b0}}, do_w};
    rp_d = rp_q + {{AW{1'b0}}, do_r};
  end
  // pointer registers, emptied on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  // storage needs no reset: nothing is readable until written
  always_ff @(posedge clk) begin
    if (do_w) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/glitch_cmd_processor.sv
// glitch_cmd_processor: host byte-protocol decoder driving NUM_CH glitch channels
module glitch_cmd_processor
  import glitch_cmd_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int PARAM_BYTES    = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int RESET_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  input  logic                            tx_release,
  input  logic                            tx_ready,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  output logic                            target_reset,
  output logic [NUM_CH*8*PARAM_BYTES-1:0] duration,
  output logic [NUM_CH*8*PARAM_BYTES-1:0] offset,
  output logic [NUM_CH-1:0]               start_offset_counter,
  output logic [NUM_CH-1:0]               armed,
  output logic                            cmd_error,
  output logic                            fifo_overflow
);
  localparam int PW = 8*PARAM_BYTES;
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] NCH = 8'(NUM_CH);
  localparam logic [7:0] CH_MASK = 8'((1 << NUM_CH) - 1);
  localparam logic [7:0] LAST_LOAD = 8'(PARAM_BYTES - 1);
  localparam logic [7:0] LAST_RB = 8'(2*PARAM_BYTES - 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RST_LEN = 32'(RESET_CYCLES);
  cmd_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, ch_q, ch_d, fifo_din, rb_byte;
  logic is_off_q, is_off_d, err_q, err_d, trst_q, trst_d, ovf_q, ovf_d;
  logic [PW-1:0] shadow_q, shadow_d, shadow_nx;
  logic [NUM_CH-1:0][PW-1:0] dur_q, dur_d, off_q, off_d;
  logic [NUM_CH-1:0] armed_q, armed_d, sor_q, sor_d;
  logic [31:0] rst_cnt_q, rst_cnt_d, to_cnt_q, to_cnt_d;
  logic [2*PW-1:0] rb_word;
  logic [CHW-1:0] ch_idx;
  logic timeout, ch_ok, rx_ch_ok, fifo_wen, fifo_full, fifo_empty, pop, waiting;
  assign ch_idx = ch_q[CHW-1:0];
  assign ch_ok = ch_q < NCH;
  assign rx_ch_ok = rx_data < NCH;
  assign shadow_nx = PW'({rx_data, shadow_q} >> 8);
  assign rb_word = {off_q[ch_idx], dur_q[ch_idx]};
  assign rb_byte = 8'(rb_word >> {cnt_q, 3'b000});
  assign waiting = state_q != IDLE && state_q != READBACK;
  assign timeout = TIMEOUT_CYCLES != 0 && waiting && !rx_valid && to_cnt_q == TO_LAST;
  assign to_cnt_d = (waiting && !rx_valid) ? to_cnt_q + 32'd1 : 32'd0;
  assign tx_valid = !fifo_empty & tx_release;
  assign pop = tx_valid & tx_ready;
  assign trst_d = rst_cnt_d != 32'd0;
  assign duration = dur_q;
  assign offset = off_q;
  assign armed = armed_q;
  assign start_offset_counter = sor_q;
  assign cmd_error = err_q;
  assign target_reset = trst_q;
  assign fifo_overflow = ovf_q;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wen(fifo_wen), .din(fifo_din), .ren(pop),
    .dout(tx_data), .empty(fifo_empty), .full(fifo_full)
  );
  // state register; reset aborts any command in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: each accepted byte advances the protocol, timeout forces IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (rx_valid) state_d = rx_data == OP_PASS ? PASS_LEN :
                                    (rx_data == OP_SET_DUR || rx_data == OP_SET_OFF) ? SEL_CH :
                                    rx_data == OP_ARM ? ARM_MASK :
                                    rx_data == OP_READBACK ? RB_SEL : IDLE;
      PASS_LEN: if (rx_valid) state_d = rx_data == 8'd0 ? IDLE : PIPE;
      PIPE:     if (rx_valid && cnt_q == 8'd1) state_d = IDLE;
      SEL_CH:   if (rx_valid) state_d = LOAD;
      LOAD:     if (rx_valid && cnt_q == LAST_LOAD) state_d = IDLE;
      ARM_MASK: if (rx_valid) state_d = IDLE;
      RB_SEL:   if (rx_valid) state_d = rx_ch_ok ? READBACK : IDLE;
      READBACK: if (cnt_q == LAST_RB) state_d = READBACK == state_q ? IDLE : state_q;
      default:  state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end
  // datapath: shadow shifting, atomic commits, arming, FIFO pushes and error pulses
  always_comb begin
    cnt_d = cnt_q;
    ch_d = ch_q;
    is_off_d = is_off_q;
    shadow_d = shadow_q;
    dur_d = dur_q;
    off_d = off_q;
    armed_d = armed_q;
    sor_d = '0;
    err_d = 1'b0;
    rst_cnt_d = rst_cnt_q == 32'd0 ? 32'd0 : rst_cnt_q - 32'd1;
    ovf_d = ovf_q;
    fifo_wen = 1'b0;
    fifo_din = rx_data;
    unique case (state_q)
      IDLE: if (rx_valid) begin
        is_off_d = rx_data == OP_SET_OFF;
        err_d = rx_data > OP_READBACK;
        if (rx_data == OP_RESET) begin
          rst_cnt_d = RST_LEN;
          ovf_d = 1'b0;
        end
      end
      PASS_LEN: if (rx_valid) begin
        cnt_d = rx_data;
        sor_d = armed_q;
        armed_d = '0;
      end
      PIPE: if (rx_valid) begin
        fifo_wen = 1'b1;
        cnt_d = cnt_q - 8'd1;
      end
      SEL_CH: if (rx_valid) begin
        ch_d = rx_data;
        cnt_d = 8'd0;
        shadow_d = '0;
      end
      LOAD: if (rx_valid) begin
        shadow_d = shadow_nx;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_LOAD) begin
          err_d = !ch_ok;
          if (ch_ok && is_off_q) off_d[ch_idx] = shadow_nx;
          if (ch_ok && !is_off_q) dur_d[ch_idx] = shadow_nx;
        end
      end
      ARM_MASK: if (rx_valid) begin
        armed_d = rx_data[NUM_CH-1:0];
        err_d = |(rx_data & ~CH_MASK);
      end
      RB_SEL: if (rx_valid) begin
        ch_d = rx_data;
        cnt_d = 8'd0;
        err_d = !rx_ch_ok;
      end
      READBACK: begin
        fifo_wen = 1'b1;
        fifo_din = rb_byte;
        cnt_d = cnt_q + 8'd1;
        err_d = rx_valid;
      end
      default: ;
    endcase
    if (timeout) begin
      err_d = 1'b1;
      shadow_d = '0;
    end
    ovf_d = ovf_d | (fifo_wen & fifo_full & !pop);
  end
  // datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ch_q <= '0;
      is_off_q <= 1'b0;
      shadow_q <= '0;
      dur_q <= '0;
      off_q <= '0;
      armed_q <= '0;
      sor_q <= '0;
      err_q <= 1'b0;
      rst_cnt_q <= '0;
      trst_q <= 1'b0;
      ovf_q <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ch_q <= ch_d;
      is_off_q <= is_off_d;
      shadow_q <= shadow_d;
      dur_q <= dur_d;
      off_q <= off_d;
      armed_q <= armed_d;
      sor_q <= sor_d;
      err_q <= err_d;
      rst_cnt_q <= rst_cnt_d;
      trst_q <= trst_d;
      ovf_q <= ovf_d;
      to_cnt_q <= to_cnt_d;
    end
  end
endmodule
